arbiter_merge: RTL and testbench
================================

ARBITER_MERGE -- requirements
Module: arbiter_merge

Interface
REQ-001 Parameter p_nbits, default 32: width of merged output message; top $clog2(p_ninputs) bits carry source index.
REQ-002 Parameter p_ninputs, default 8: number of input channels; power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid  input  1 x [0:p_ninputs-1]  per-input valid.
REQ-006 ready_out  output  1 x [0:p_ninputs-1]  per-input ready; high only for the granted input.
REQ-007 message_in  input  (p_nbits-$clog2(p_ninputs)) x [0:p_ninputs-1]  per-input payload.
REQ-008 valid_out  output  1  merged output valid.
REQ-009 ready  input  1  downstream ready.
REQ-010 message_out  output  p_nbits  {source index, payload}; index in MSBs, payload in LSBs.

Function
REQ-011 Block SHALL be the inverse of the address-based router: N valid/ready channels merged onto one, source index prepended so the router can route it back.
REQ-012 Transfer on input i occurs in a cycle where valid[i] && ready_out[i]; output transfer where valid_out && ready.
REQ-013 One-entry output register (full flag, index, payload); valid_out SHALL equal full flag, message_out SHALL equal registered contents.
REQ-014 Register can accept when !full or (full && ready); "accept" is combinational from full and ready.
REQ-015 Grant: among inputs with valid high, first at or after pointer ptr in ascending modulo order; at most one ready_out high per cycle.
REQ-016 ready_out[g] SHALL be high iff accept && valid[g] && g is granted; all other ready_out low; no ready_out depends on any ready_out.
REQ-017 On input transfer from g: register loads {g, message_in[g]}, full set, ptr <= (g+1) mod p_ninputs.
REQ-018 Output transfer with no input transfer: full cleared; ptr unchanged.
REQ-019 Simultaneous output and input transfer: register replaced, full stays 1; sustains one message per cycle.
REQ-020 No valid input: no grant, ptr unchanged, register holds unless drained.
REQ-021 Full and ready low: all ready_out low; register and ptr hold (backpressure).
REQ-022 Latency: input transfer in cycle t -> valid_out high from cycle t+1.
REQ-023 Fairness: with all inputs continuously valid and ready high, grants SHALL rotate 0,1,...,N-1,0...; no input starves longer than p_ninputs-1 grants.
REQ-024 ptr wraps from p_ninputs-1 to 0.
REQ-025 Messages from one input SHALL leave in arrival order; payload bits unmodified.

Reset
REQ-026 While reset high: full=0 (valid_out=0), ptr=0, index/payload=0, all ready_out=0 regardless of valid/ready.
REQ-027 Reset asserted mid-transfer SHALL discard the held message immediately (asynchronously); first grant after deassertion starts at input 0.

Structure
REQ-028 Shared package holds index-width constant/function ($clog2(p_ninputs)) and payload-width derivation, shared with the router.
REQ-029 One sub-module: roundRobinArbiterVRTL (request vector, enable, pointer state, one-hot grant plus encoded index); datapath and output register live in arbiter_merge.

Verification (p_nbits=32, p_ninputs=8, payload 29 bits)
REQ-030 After reset, valid[3]=1, message_in[3]=29'h0ABCDEF, ready=1 -> ready_out[3]=1 that cycle; next cycle valid_out=1, message_out=32'h60ABCDEF.
REQ-031 All 8 valid continuously, ready=1, payload=i -> output index sequence 0,1,2,...,7,0 on consecutive cycles, one per cycle.
REQ-032 Register full, ready=0 for 5 cycles, valid[1]=1 -> all ready_out low, message_out stable 5 cycles; ready=1 -> drain and accept input 1 same cycle.
REQ-033 ptr=6 (after grant to 5), valid[2] and valid[7] high -> grant 7, then 2 (wrap).
REQ-034 Reset asserted while full with valid_out=1 -> valid_out drops to 0 without clock edge; after release, valid[0..7] all high -> first grant is 0.
REQ-035 Random valid/ready over 10k cycles, scoreboard per input -> no loss, duplication or reordering; index field matches source.

Source files
------------

// File: rtl/arbiter_merge_pkg.sv
// Shared width helpers for the merge/route pair: index width and payload width
// derived from the channel count and total message width.
package arbiter_merge_pkg;

    localparam int NBITS_DEFAULT   = 32;
    localparam int NINPUTS_DEFAULT = 8;

    function automatic int idx_width(input int ninputs);
        return (ninputs > 1) ? $clog2(ninputs) : 1;
    endfunction

    function automatic int payload_width(input int nbits, input int ninputs);
        return nbits - idx_width(ninputs);
    endfunction

endpackage

// File: rtl/arbiter_merge_rr.sv
// Round-robin arbiter: picks the first request at or after the pointer and
// advances the pointer past the winner whenever the grant is consumed.
module roundRobinArbiterVRTL
    import arbiter_merge_pkg::*;
#(
    parameter int p_nreqs = NINPUTS_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [p_nreqs-1:0]              req_i,
    input  logic                            en_i,
    output logic [p_nreqs-1:0]              grant_o,
    output logic [idx_width(p_nreqs)-1:0]   grant_idx_o,
    output logic                            grant_vld_o
);
    localparam int LW = idx_width(p_nreqs);

    logic [LW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] cand_s;
    logic          found_s;

    // Modulo search from the pointer; power-of-two count makes the wrap a truncation
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        cand_s      = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            cand_s = ptr_q + LW'(i);
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                grant_idx_o     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        grant_vld_o = found_s;
    end

    // Pointer next-state: move just past the winner only on a consumed grant
    always_comb begin
        ptr_d = ptr_q;
        if (en_i && grant_vld_o) begin
            ptr_d = grant_idx_o + LW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arbiter_merge.sv
// N-to-1 valid/ready merge: round-robin grant into a one-entry output register,
// with the source index prepended so the matching router can send it back.
module arbiter_merge
    import arbiter_merge_pkg::*;
#(
    parameter int p_nbits   = NBITS_DEFAULT,
    parameter int p_ninputs = NINPUTS_DEFAULT
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          valid      [0:p_ninputs-1],
    output logic                                          ready_out  [0:p_ninputs-1],
    input  logic [payload_width(p_nbits, p_ninputs)-1:0]  message_in [0:p_ninputs-1],
    output logic                                          valid_out,
    input  logic                                          ready,
    output logic [p_nbits-1:0]                            message_out
);
    localparam int IW = idx_width(p_ninputs);
    localparam int PW = payload_width(p_nbits, p_ninputs);

    logic [p_ninputs-1:0] req_s;
    logic [p_ninputs-1:0] grant_s;
    logic [IW-1:0]        grant_idx_s;
    logic                 grant_vld_s;
    logic                 accept_s;
    logic                 in_xfer_s;
    logic                 out_xfer_s;

    logic                 full_q, full_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        payload_q, payload_d;

    // Reset gating keeps every ready_out low while reset is held
    assign accept_s   = !reset && (!full_q || ready);
    assign in_xfer_s  = accept_s && grant_vld_s;
    assign out_xfer_s = full_q && ready;

    // Pack per-channel valids into the arbiter request vector
    always_comb begin
        req_s = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            req_s[i] = valid[i];
        end
    end

    roundRobinArbiterVRTL #(
        .p_nreqs     (p_ninputs)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_s),
        .en_i        (accept_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s),
        .grant_vld_o (grant_vld_s)
    );

    // Ready only to the granted channel, derived from register state, never from other readies
    always_comb begin
        for (int i = 0; i < p_ninputs; i++) begin
            ready_out[i] = accept_s && grant_s[i];
        end
    end

    // Output register next-state: load wins over drain so back-to-back transfers sustain
    always_comb begin
        full_d    = full_q;
        idx_d     = idx_q;
        payload_d = payload_q;
        if (in_xfer_s) begin
            full_d    = 1'b1;
            idx_d     = grant_idx_s;
            payload_d = message_in[grant_idx_s];
        end else if (out_xfer_s) begin
            full_d    = 1'b0;
        end else begin
            full_d    = full_q;
        end
    end

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= 1'b0;
            idx_q     <= '0;
            payload_q <= '0;
        end else begin
            full_q    <= full_d;
            idx_q     <= idx_d;
            payload_q <= payload_d;
        end
    end

    assign valid_out   = full_q;
    assign message_out = {idx_q, payload_q};

endmodule

// File: tb/tb_arbiter_merge.sv
// Bench for arbiter_merge: behavioural grant/register model plus a queue of
// expected output messages, with directed corner cases and a random soak.
module tb_arbiter_merge;
    localparam int N  = 8;
    localparam int NB = 32;
    localparam int PW = 29;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid      [0:N-1];
    logic          ready_out  [0:N-1];
    logic [PW-1:0] message_in [0:N-1];
    logic          valid_out;
    logic          ready;
    logic [NB-1:0] message_out;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   sbq[$];
    logic          m_full = 1'b0;
    int            m_ptr  = 0;
    int            last_grant;
    logic [31:0]   obs_msg;
    logic          obs_vo;
    logic [31:0]   held;

    arbiter_merge #(.p_nbits(NB), .p_ninputs(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .ready_out   (ready_out),
        .message_in  (message_in),
        .valid_out   (valid_out),
        .ready       (ready),
        .message_out (message_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pack_ro();
        logic [7:0] v;
        for (int i = 0; i < N; i++) v[i] = ready_out[i];
        return v;
    endfunction

    task automatic set_valid(input logic [7:0] v);
        for (int i = 0; i < N; i++) valid[i] = v[i];
    endtask

    // One cycle: check outputs against the model at negedge, then advance the model.
    task automatic step();
        logic [7:0] exp_ro;
        logic       acc, inx, outx;
        int         g, idx;
        @(negedge clk);
        acc = !m_full || ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && valid[idx]) g = idx;
        end
        exp_ro = 8'h00;
        inx = acc && (g >= 0);
        if (inx) exp_ro[g] = 1'b1;
        chk("ready_out", {24'h0, pack_ro()}, {24'h0, exp_ro});
        chk("valid_out", {31'h0, valid_out}, {31'h0, m_full});
        obs_msg = message_out;
        obs_vo  = valid_out;
        outx = m_full && ready;
        if (m_full) begin
            if (sbq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_empty: got empty queue expected one entry");
            end else begin
                chk("message_out", message_out, sbq[0]);
                if (outx) void'(sbq.pop_front());
            end
        end
        if (inx) sbq.push_back({3'(g), message_in[g]});
        last_grant = inx ? g : -1;
        @(posedge clk);
        #1;
        if (inx) begin
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (outx) begin
            m_full = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b1;
        set_valid(8'hFF);
        for (int i = 0; i < N; i++) message_in[i] = PW'($urandom);
        #12;
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_ready_out", {24'h0, pack_ro()}, 32'h0);
        chk("rst_msg", message_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_valid(8'h00);

        // Single transfer from input 3
        valid[3] = 1'b1; message_in[3] = 29'h0ABCDEF;
        step();
        chk("t30_grant", last_grant, 32'd3);
        valid[3] = 1'b0;
        step();
        chk("t30_vo", {31'h0, obs_vo}, 32'd1);
        chk("t30_msg", obs_msg, 32'h60ABCDEF);

        // Pointer wrap: grant 5, then 7 before 2
        valid[5] = 1'b1;
        step();
        chk("wrap_g5", last_grant, 32'd5);
        set_valid(8'h84);
        step();
        chk("wrap_g7", last_grant, 32'd7);
        step();
        chk("wrap_g2", last_grant, 32'd2);

        // Backpressure for 5 cycles, then drain and accept input 1 together
        set_valid(8'h02);
        ready = 1'b0;
        held  = message_out;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_nogrant", last_grant, 32'hFFFFFFFF);
            chk("bp_stable", obs_msg, held);
        end
        ready = 1'b1;
        step();
        chk("bp_release_g1", last_grant, 32'd1);

        // Asynchronous reset while full
        set_valid(8'h00);
        reset = 1'b1;
        #1;
        chk("arst_vo", {31'h0, valid_out}, 32'h0);
        set_valid(8'hFF);
        #1;
        chk("arst_ro", {24'h0, pack_ro()}, 32'h0);
        chk("arst_msg", message_out, 32'h0);
        m_full = 1'b0; m_ptr = 0; sbq.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        // All inputs valid: grants and outputs rotate from 0
        for (int i = 0; i < N; i++) message_in[i] = PW'(i);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k <= 8) chk("rot_grant", last_grant, 32'(k % N));
            if (k >= 1) begin
                chk("rot_vo", {31'h0, obs_vo}, 32'd1);
                chk("rot_idx", {29'h0, obs_msg[31:29]}, 32'((k - 1) % N));
            end
        end

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                valid[i]      = 1'($urandom_range(0, 1));
                message_in[i] = PW'($urandom);
            end
            ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
